pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Central sequencing controller for the integer pipeline around the ALU stage. It keeps a destination scoreboard of in-flight instructions and uses it to drive the ALU stage's operand forwarding selects and the decode stall. It also owns the late-branch redirect: fetch request, wrong-path flush and the br_late_done pulse back to the ALU stage. It sits between decode, fetch and the EX / LA (late ALU / mem) / WB stages.

Parameters:
FLUSH_CYCLES, 2, cycles flush_if_id is held after a redirect is accepted (1..15)
KIND_W, 2, width of the result-kind code

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
id_valid  in  1  decode holds a real instruction
id_rs  in  5  source register A index
id_rt  in  5  source register B index
id_uses_rs  in  1  instruction reads rs
id_uses_rt  in  1  instruction reads rt
id_rd  in  5  final destination index (after rs/rt override); 0 = no write
id_kind  in  KIND_W  result availability: 0 ALU at EX, 1 LATE at LA, 2 LOAD at WB
br_late_enable  in  1  registered ALU-stage late-branch request
br_target  in  32  redirect PC
redirect_ready  in  1  fetch accepts redirect
stall_id  out  1  hold IF/ID; inject bubble into EX
flush_if_id  out  1  squash IF/ID contents
fwd_rs_sel  out  2  0 regfile, 1 EX result, 2 LA result, 3 WB result
fwd_rt_sel  out  2  same encoding for rt
redirect_valid  out  1  redirect request to fetch
redirect_pc  out  32  redirect target, stable while redirect_valid
br_late_done  out  1  one-cycle pulse: redirect complete
br_err  out  1  sticky: br_late_enable seen while not IDLE

Behaviour:
- Reset: all scoreboard entries invalid. FSM IDLE. All outputs 0. redirect_pc 0.
- Scoreboard: three registered entries EX, LA, WB, each {valid, rd, kind}. Every cycle WB<=LA and LA<=EX.
- EX loads {id_valid & ~stall_id & ~flush_if_id, id_rd, id_kind}. Otherwise EX loads a bubble (valid=0).
- Match: entry valid, rd!=0, rd equals the used source index.
- Stall (combinational), for each used source:
  - EX match with kind LATE or LOAD -> stall.
  - LA match with kind LOAD -> stall.
  - stall_id is forced to 0 while flush_if_id=1.
- Forward select (combinational): youngest match wins, EX > LA > WB. No match -> 0. Sources with uses=0 -> 0.
- Branch FSM:
  - IDLE: on br_late_enable, latch br_target into redirect_pc and go to REQ.
  - REQ: redirect_valid=1. On redirect_ready, go to FLUSH and load counter=FLUSH_CYCLES.
  - FLUSH: flush_if_id=1; counter decrements each cycle. Exit to DONE after FLUSH_CYCLES cycles.
  - DONE: br_late_done=1 for exactly one cycle, then IDLE.
- Latency: br_late_enable to redirect_valid is 1 cycle. Minimum br_late_enable to br_late_done is FLUSH_CYCLES+2 cycles when redirect_ready is already high.
- br_late_enable outside IDLE: ignored, br_err set (cleared only by reset).
- Simultaneous stall and branch in IDLE: the branch is accepted and the stall continues normally. The delay slot is already in EX, so it is never squashed.
- Reset mid-redirect: FSM returns to IDLE, redirect_valid drops in the same clock, no br_late_done.

Optional Feature:
PIPELINE_FWD_EN
- Defined: forwarding as above.
- Undefined: fwd_*_sel tied 0. Any EX/LA/WB match on a used source stalls until that entry leaves WB (regfile write-through assumed at WB).

Decomposition:
- Package pipeline_pkg: kind codes (KIND_ALU=0, KIND_LATE=1, KIND_LOAD=2), forward-select codes (FWD_RF..FWD_WB), FSM state encoding.
- One sub-module is natural: pipeline_br_redirect_fsm (IDLE/REQ/FLUSH/DONE, counter, br_err), instantiated in pipeline_hazard_ctrl.

Test Plan:
- ALU->ALU: EX {rd=5, kind ALU}; ID uses rs=5 -> stall_id=0, fwd_rs_sel=1. Next cycle, with a new non-matching ID instruction, fwd_rs_sel=2 (LA match).
- Load-use: EX {rd=8, LOAD}; ID rt=8 -> stall 2 cycles. Third cycle stall_id=0, fwd_rt_sel=3.
- Shift-use: EX {rd=3, LATE}; ID rs=3 -> stall 1 cycle, then fwd_rs_sel=2.
- rd=0 writer in EX; ID rs=0 -> no stall, fwd_rs_sel=0.
- Branch: br_late_enable with br_target=0x00400100 and redirect_ready low 3 cycles -> redirect_valid held 3 cycles with pc 0x00400100. Then flush_if_id for 2 cycles, br_late_done for 1 cycle, FSM back in IDLE.
- br_late_enable again during FLUSH -> ignored, br_err=1. rst during REQ -> redirect_valid=0 next cycle, br_err=0.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared codes for the integer pipeline hazard controller:
// result kinds, forward selects and redirect FSM states.
package pipeline_pkg;

  localparam logic [1:0] KIND_ALU  = 2'd0;
  localparam logic [1:0] KIND_LATE = 2'd1;
  localparam logic [1:0] KIND_LOAD = 2'd2;

  typedef enum logic [1:0] {
    FWD_RF = 2'd0,
    FWD_EX = 2'd1,
    FWD_LA = 2'd2,
    FWD_WB = 2'd3
  } fwd_sel_e;

  typedef enum logic [1:0] {
    BR_IDLE  = 2'd0,
    BR_REQ   = 2'd1,
    BR_FLUSH = 2'd2,
    BR_DONE  = 2'd3
  } br_state_e;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Decode / fetch / ALU-stage signal bundle of the hazard controller.
// master = pipeline side driving requests, slave = the controller.
interface pipeline_hazard_ctrl_if #(
  parameter int KIND_W = 2
);
  logic              id_valid;
  logic [4:0]        id_rs;
  logic [4:0]        id_rt;
  logic              id_uses_rs;
  logic              id_uses_rt;
  logic [4:0]        id_rd;
  logic [KIND_W-1:0] id_kind;
  logic              br_late_enable;
  logic [31:0]       br_target;
  logic              redirect_ready;
  logic              stall_id;
  logic              flush_if_id;
  logic [1:0]        fwd_rs_sel;
  logic [1:0]        fwd_rt_sel;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic              br_late_done;
  logic              br_err;

  modport master (
    output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
    output id_rd, id_kind,
    output br_late_enable, br_target, redirect_ready,
    input  stall_id, flush_if_id, fwd_rs_sel, fwd_rt_sel,
    input  redirect_valid, redirect_pc, br_late_done, br_err
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
    input  id_rd, id_kind,
    input  br_late_enable, br_target, redirect_ready,
    output stall_id, flush_if_id, fwd_rs_sel, fwd_rt_sel,
    output redirect_valid, redirect_pc, br_late_done, br_err
  );
endinterface

// File: rtl/pipeline_br_redirect_fsm.sv
// Late-branch redirect sequencer: IDLE -> REQ -> FLUSH -> DONE,
// with the flush hold counter and the sticky br_err flag.
module pipeline_br_redirect_fsm #(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        br_late_enable,
  input  logic [31:0] br_target,
  input  logic        redirect_ready,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        flush_if_id,
  output logic        br_late_done,
  output logic        br_err
);
  import pipeline_pkg::*;

  br_state_e   state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] pc_q;
  logic        err_q;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    redirect_valid = 1'b0;
    flush_if_id    = 1'b0;
    br_late_done   = 1'b0;
    unique case (state_q)
      BR_IDLE: begin
        if (br_late_enable) state_d = BR_REQ;
      end
      BR_REQ: begin
        redirect_valid = 1'b1;
        if (redirect_ready) begin
          state_d = BR_FLUSH;
          cnt_d   = 4'(FLUSH_CYCLES);
        end
      end
      BR_FLUSH: begin
        flush_if_id = 1'b1;
        cnt_d       = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = BR_DONE;
      end
      BR_DONE: begin
        br_late_done = 1'b1;
        state_d      = BR_IDLE;
      end
      default: state_d = BR_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BR_IDLE;
      cnt_q   <= 4'd0;
      pc_q    <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (br_late_enable && state_q == BR_IDLE)
        pc_q <= br_target;
      // a second late branch can't be queued behind the first
      if (br_late_enable && state_q != BR_IDLE)
        err_q <= 1'b1;
    end
  end

  assign redirect_pc = pc_q;
  assign br_err      = err_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Destination scoreboard, stall/forward control and late-branch redirect.
// Define PIPELINE_FWD_EN for operand forwarding; otherwise stall-only.
module pipeline_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int KIND_W       = 2
) (
  input  logic clk,
  input  logic rst,
  pipeline_hazard_ctrl_if.slave bus
);
  import pipeline_pkg::*;

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
  } sb_t;

  sb_t  ex_q, la_q, wb_q;
  logic stall_raw, stall, flush;
  logic rs_ex, rs_la, rs_wb, rt_ex, rt_la, rt_wb;

  always_comb begin
    rs_ex = bus.id_uses_rs && ex_q.v && ex_q.rd != 5'd0 && ex_q.rd == bus.id_rs;
    rs_la = bus.id_uses_rs && la_q.v && la_q.rd != 5'd0 && la_q.rd == bus.id_rs;
    rs_wb = bus.id_uses_rs && wb_q.v && wb_q.rd != 5'd0 && wb_q.rd == bus.id_rs;
    rt_ex = bus.id_uses_rt && ex_q.v && ex_q.rd != 5'd0 && ex_q.rd == bus.id_rt;
    rt_la = bus.id_uses_rt && la_q.v && la_q.rd != 5'd0 && la_q.rd == bus.id_rt;
    rt_wb = bus.id_uses_rt && wb_q.v && wb_q.rd != 5'd0 && wb_q.rd == bus.id_rt;
  end

`ifdef PIPELINE_FWD_EN
  localparam logic [KIND_W-1:0] K_LATE = KIND_W'(KIND_LATE);
  localparam logic [KIND_W-1:0] K_LOAD = KIND_W'(KIND_LOAD);

  logic [KIND_W-1:0] ex_k, la_k;
  logic              ex_late;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_k <= '0;
      la_k <= '0;
    end else begin
      ex_k <= bus.id_kind;
      la_k <= ex_k;
    end
  end

  // a result not yet produced can't be forwarded
  assign ex_late   = ex_k == K_LATE || ex_k == K_LOAD;
  assign stall_raw = ((rs_ex || rt_ex) && ex_late) ||
                     ((rs_la || rt_la) && la_k == K_LOAD);

  always_comb begin
    bus.fwd_rs_sel = FWD_RF;
    if (rs_ex)      bus.fwd_rs_sel = FWD_EX;
    else if (rs_la) bus.fwd_rs_sel = FWD_LA;
    else if (rs_wb) bus.fwd_rs_sel = FWD_WB;
  end

  always_comb begin
    bus.fwd_rt_sel = FWD_RF;
    if (rt_ex)      bus.fwd_rt_sel = FWD_EX;
    else if (rt_la) bus.fwd_rt_sel = FWD_LA;
    else if (rt_wb) bus.fwd_rt_sel = FWD_WB;
  end
`else
  assign stall_raw = rs_ex || rs_la || rs_wb || rt_ex || rt_la || rt_wb;
  assign bus.fwd_rs_sel = FWD_RF;
  assign bus.fwd_rt_sel = FWD_RF;
`endif

  // flushed IF/ID is discarded, so holding it is pointless
  assign stall = stall_raw && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q <= '0;
      la_q <= '0;
      wb_q <= '0;
    end else begin
      wb_q    <= la_q;
      la_q    <= ex_q;
      ex_q.v  <= bus.id_valid && !stall && !flush;
      ex_q.rd <= bus.id_rd;
    end
  end

  pipeline_br_redirect_fsm #(
    .FLUSH_CYCLES(FLUSH_CYCLES)
  ) u_br (
    .clk           (clk),
    .rst           (rst),
    .br_late_enable(bus.br_late_enable),
    .br_target     (bus.br_target),
    .redirect_ready(bus.redirect_ready),
    .redirect_valid(bus.redirect_valid),
    .redirect_pc   (bus.redirect_pc),
    .flush_if_id   (flush),
    .br_late_done  (bus.br_late_done),
    .br_err        (bus.br_err)
  );

  assign bus.flush_if_id = flush;
  assign bus.stall_id    = stall;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench: stimulus pushes reference expectations,
// a negedge monitor pops and compares them against the controller.
module tb_pipeline_hazard_ctrl;

  localparam int FLUSH = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.KIND_W(2)) bus ();

  pipeline_hazard_ctrl #(
    .FLUSH_CYCLES(FLUSH),
    .KIND_W      (2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    bit v;
    int rd;
    int kind;
  } ent_t;

  typedef struct {
    int          cyc;
    bit          stall, flush, rv, done, err;
    int          fs, ft;
    bit [31:0]   pc;
  } exp_t;

  exp_t q[$];
  ent_t pipe[3];
  bit        req_pend, m_err;
  int        acc, cyc;
  bit [31:0] m_pc;
  int n_cmp = 0;
  int n_fail = 0;

  task automatic model_reset();
    for (int i = 0; i < 3; i++) pipe[i] = '{v: 0, rd: 0, kind: 0};
    req_pend = 0;
    m_err    = 0;
    acc      = -1000;
    m_pc     = 0;
  endtask

  // Result of age a (0=EX,1=LA,2=WB) is usable once a >= kind.
  task automatic src_eval(input bit use_s, input int src,
                          output bit st, output int sel);
    st  = 0;
    sel = 0;
    if (use_s && src != 0) begin
      for (int a = 0; a < 3; a++) begin
        if (pipe[a].v && pipe[a].rd == src) begin
`ifdef PIPELINE_FWD_EN
          if (a < pipe[a].kind) st = 1;
          if (sel == 0) sel = a + 1;
`else
          st = 1;
`endif
        end
      end
    end
  endtask

  task automatic step(input bit r, input bit iv, input int rs, input int rt,
                      input bit urs, input bit urt, input int rd, input int kind,
                      input bit en, input bit [31:0] tgt, input bit rdy);
    exp_t e;
    bit st_s, st_t, busy;
    rst = r;
    bus.id_valid = iv;
    bus.id_rs = 5'(rs);
    bus.id_rt = 5'(rt);
    bus.id_uses_rs = urs;
    bus.id_uses_rt = urt;
    bus.id_rd = 5'(rd);
    bus.id_kind = 2'(kind);
    bus.br_late_enable = en;
    bus.br_target = tgt;
    bus.redirect_ready = rdy;
    src_eval(urs, rs, st_s, e.fs);
    src_eval(urt, rt, st_t, e.ft);
    e.cyc   = cyc;
    e.flush = cyc > acc && cyc <= acc + FLUSH;
    e.done  = cyc == acc + FLUSH + 1;
    e.stall = (st_s || st_t) && !e.flush;
    e.rv    = req_pend;
    e.pc    = m_pc;
    e.err   = m_err;
    busy    = req_pend || cyc <= acc + FLUSH + 1;
    q.push_back(e);
    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = '{v: iv && !e.stall && !e.flush, rd: rd, kind: kind};
      if (req_pend && rdy) begin
        req_pend = 0;
        acc      = cyc;
      end
      if (en) begin
        if (busy) m_err = 1;
        else begin
          req_pend = 1;
          m_pc     = tgt;
        end
      end
    end
    cyc++;
    #1;
  endtask

  task automatic nop(input bit rdy);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'd0, rdy);
  endtask

  task automatic chk(input string nm, input int c, input logic [31:0] a,
                     input logic [31:0] w);
    n_cmp++;
    if (a !== w) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, c, a, w);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("stall_id",       e.cyc, 32'(bus.stall_id),       32'(e.stall));
      chk("flush_if_id",    e.cyc, 32'(bus.flush_if_id),    32'(e.flush));
      chk("fwd_rs_sel",     e.cyc, 32'(bus.fwd_rs_sel),     32'(e.fs));
      chk("fwd_rt_sel",     e.cyc, 32'(bus.fwd_rt_sel),     32'(e.ft));
      chk("redirect_valid", e.cyc, 32'(bus.redirect_valid), 32'(e.rv));
      chk("redirect_pc",    e.cyc, bus.redirect_pc,         e.pc);
      chk("br_late_done",   e.cyc, 32'(bus.br_late_done),   32'(e.done));
      chk("br_err",         e.cyc, 32'(bus.br_err),         32'(e.err));
    end
  end

  initial begin
    int wait_cnt;
    cyc = 0;
    model_reset();
    bus.id_valid = 0;
    bus.id_rs = 0;
    bus.id_rt = 0;
    bus.id_uses_rs = 0;
    bus.id_uses_rt = 0;
    bus.id_rd = 0;
    bus.id_kind = 0;
    bus.br_late_enable = 0;
    bus.br_target = 0;
    bus.redirect_ready = 0;
    rst = 1;
    repeat (2) @(posedge clk);
    #1;

    // reset state
    nop(0);
    // ALU -> ALU: EX forward, then LA forward
    step(0, 1, 0, 0, 0, 0, 5, 0, 0, 0, 0);
    step(0, 1, 5, 0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 5, 1, 1, 0, 0, 0, 0, 0, 0);
    // load-use on rt
    step(0, 1, 0, 0, 0, 0, 8, 2, 0, 0, 0);
    repeat (3) step(0, 1, 0, 8, 0, 1, 0, 0, 0, 0, 0);
    // shift-use on rs
    step(0, 1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
    repeat (2) step(0, 1, 3, 0, 1, 0, 0, 0, 0, 0, 0);
    // r0 writer never matches
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    repeat (3) nop(0);

    // redirect with fetch busy for 3 cycles, re-request during flush
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0040_0100, 0);
    repeat (2) nop(0);
    nop(1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h1234_5678, 0);
    repeat (4) nop(0);
    // reset while redirect is pending
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0000_0abc, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) nop(1);

    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 499) == 0,
           $urandom_range(0, 9) < 8,
           $urandom_range(0, 7), $urandom_range(0, 7),
           1'($urandom), 1'($urandom),
           $urandom_range(0, 7), $urandom_range(0, 2),
           $urandom_range(0, 15) == 0, $urandom,
           1'($urandom));
    end
    nop(1);

    wait_cnt = 0;
    while (q.size() > 0 && wait_cnt < 10) begin
      @(posedge clk);
      wait_cnt++;
    end
    #1;
    if (q.size() > 0) begin
      n_fail++;
      $display("FAIL drain queue=%0d left", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
